// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - BCD MM:SS countdown timer driven by a 1 Hz tick
module countdown_timer #(
  parameter bit p_auto_reload = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic [7:0] i_load_min,
  input  logic [7:0] i_load_sec,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [7:0] o_min,
  output logic [7:0] o_sec,
  output logic       o_busy,
  output logic       o_stop,
  output logic       o_done,
  output logic       o_expired,
  output logic       o_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t     state, state_nx;
  logic [7:0] min_q, sec_q, min_nx, sec_nx;
  logic [7:0] rld_min, rld_sec, rld_min_nx, rld_sec_nx;
  logic       done_q, done_nx, err_q, err_nx;
  logic [7:0] dec_min, dec_sec;
  logic       load_ok, is_zero, dec_zero;

  assign load_ok = (i_load_min[7:4] <= 4'd9) && (i_load_min[3:0] <= 4'd9) &&
                   (i_load_sec[7:4] <= 4'd5) && (i_load_sec[3:0] <= 4'd9) &&
                   ((i_load_min | i_load_sec) != 8'h00);
  assign is_zero  = (min_q == 8'h00) && (sec_q == 8'h00);
  assign dec_zero = (dec_min == 8'h00) && (dec_sec == 8'h00);

  // One-second BCD decrement; only used when the value is non-zero.
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_q[3:0] - 4'd1;
    end else if (sec_q[7:4] != 4'd0) begin
      dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec = 8'h59;
      if (min_q[3:0] != 4'd0) dec_min[3:0] = min_q[3:0] - 4'd1;
      else                    dec_min = {min_q[7:4] - 4'd1, 4'd9};
    end
  end

  always_comb begin
    state_nx   = state;
    min_nx     = min_q;
    sec_nx     = sec_q;
    rld_min_nx = rld_min;
    rld_sec_nx = rld_sec;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    if (i_load) begin
      if (load_ok) begin
        min_nx     = i_load_min;
        sec_nx     = i_load_sec;
        rld_min_nx = i_load_min;
        rld_sec_nx = i_load_sec;
        state_nx   = IDLE;
      end else begin
        err_nx = 1'b1;
      end
    end else if (i_pause) begin
      if (state == RUN) state_nx = PAUSE;
    end else if (i_start) begin
      if ((state == IDLE && !is_zero) || state == PAUSE) state_nx = RUN;
    end else if (i_tick && state == RUN) begin
      // Zero while running only happens with auto-reload: the next tick reloads.
      if (is_zero) begin
        min_nx = rld_min;
        sec_nx = rld_sec;
      end else begin
        min_nx = dec_min;
        sec_nx = dec_sec;
        if (dec_zero) begin
          done_nx = 1'b1;
          if (!p_auto_reload) state_nx = EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      rld_min <= 8'h00;
      rld_sec <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      min_q   <= min_nx;
      sec_q   <= sec_nx;
      rld_min <= rld_min_nx;
      rld_sec <= rld_sec_nx;
      done_q  <= done_nx;
      err_q   <= err_nx;
    end
  end

  assign o_min     = min_q;
  assign o_sec     = sec_q;
  assign o_busy    = (state == RUN);
  assign o_stop    = (state != RUN);
  assign o_expired = (state == EXPIRED);
  assign o_done    = done_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer, both reload modes
module tb_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [7:0] lmin = 8'h00, lsec = 8'h00;

  logic [7:0] min0, sec0, min1, sec1;
  logic       busy0, stop0, done0, exp0, err0;
  logic       busy1, stop1, done1, exp1, err1;

  countdown_timer #(.p_auto_reload(1'b0)) u_once (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_load(load),
    .i_load_min(lmin), .i_load_sec(lsec), .i_start(start), .i_pause(pause),
    .o_min(min0), .o_sec(sec0), .o_busy(busy0), .o_stop(stop0),
    .o_done(done0), .o_expired(exp0), .o_err(err0));

  countdown_timer #(.p_auto_reload(1'b1)) u_auto (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_load(load),
    .i_load_min(lmin), .i_load_sec(lsec), .i_start(start), .i_pause(pause),
    .o_min(min1), .o_sec(sec1), .o_busy(busy1), .o_stop(stop1),
    .o_done(done1), .o_expired(exp1), .o_err(err1));

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] sc;
    logic busy, stop, done, expired, err;
  } obs_t;

  obs_t q0[$], q1[$];
  int tests = 0, fails = 0;

  // Reference model: value as whole seconds; state 0 idle, 1 run, 2 pause, 3 expired.
  int secs[2], rld[2], st[2];

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int from_bcd(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit valid_load(logic [7:0] m, logic [7:0] s);
    return m[7:4] <= 9 && m[3:0] <= 9 && s[7:4] <= 5 && s[3:0] <= 9 && (m != 0 || s != 0);
  endfunction

  task automatic model(int k, bit auto_rl);
    obs_t e;
    bit dn = 0, er = 0;
    if (rst) begin
      secs[k] = 0; rld[k] = 0; st[k] = 0;
    end else if (load) begin
      if (valid_load(lmin, lsec)) begin
        secs[k] = from_bcd(lmin) * 60 + from_bcd(lsec);
        rld[k]  = secs[k];
        st[k]   = 0;
      end else er = 1;
    end else if (pause) begin
      if (st[k] == 1) st[k] = 2;
    end else if (start) begin
      if ((st[k] == 0 && secs[k] != 0) || st[k] == 2) st[k] = 1;
    end else if (tick && st[k] == 1) begin
      if (secs[k] == 0) secs[k] = rld[k];
      else begin
        secs[k]--;
        if (secs[k] == 0) begin
          dn = 1;
          if (!auto_rl) st[k] = 3;
        end
      end
    end
    e.mn = to_bcd(secs[k] / 60);
    e.sc = to_bcd(secs[k] % 60);
    e.busy = (st[k] == 1);
    e.stop = (st[k] != 1);
    e.done = dn;
    e.expired = (st[k] == 3);
    e.err = er;
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(bit r, bit l, logic [7:0] m, logic [7:0] s, bit sa, bit pa, bit t);
    @(negedge clk);
    rst = r; load = l; lmin = m; lsec = s; start = sa; pause = pa; tick = t;
    model(0, 1'b0);
    model(1, 1'b1);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 0, 0);
  endtask
  task automatic do_load(logic [7:0] m, logic [7:0] s); step(0, 1, m, s, 0, 0, 0); endtask
  task automatic do_start(); step(0, 0, 8'h00, 8'h00, 1, 0, 0); endtask
  task automatic do_ticks(int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 8'h00, 8'h00, 0, 0, 1);
      idle(1);
    end
  endtask

  task automatic check(string nm, obs_t got, obs_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %02h:%02h busy=%b stop=%b done=%b exp=%b err=%b, expected %02h:%02h busy=%b stop=%b done=%b exp=%b err=%b",
               nm, got.mn, got.sc, got.busy, got.stop, got.done, got.expired, got.err,
               exp.mn, exp.sc, exp.busy, exp.stop, exp.done, exp.expired, exp.err);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check("once", {min0, sec0, busy0, stop0, done0, exp0, err0}, q0.pop_front());
    if (q1.size() > 0) check("auto", {min1, sec1, busy1, stop1, done1, exp1, err1}, q1.pop_front());
  end

  initial begin
    step(1, 0, 8'h00, 8'h00, 0, 0, 0);
    idle(2);
    do_load(8'h01, 8'h05); idle(1); do_start(); do_ticks(6);
    do_load(8'h00, 8'h02); do_start(); do_ticks(3); do_start(); do_ticks(1);
    do_load(8'h10, 8'h00); do_start(); do_ticks(1);
    step(0, 0, 8'h00, 8'h00, 0, 1, 1); idle(1);
    do_start(); do_ticks(1);
    do_load(8'h00, 8'h60); do_load(8'h0A, 8'h00); do_load(8'h00, 8'h00); idle(1);
    do_load(8'h00, 8'h03); do_start(); do_ticks(5);
    do_load(8'h00, 8'h45); do_start(); do_ticks(1);
    step(0, 1, 8'h00, 8'h30, 0, 0, 1); idle(1); do_start(); do_ticks(2);
    step(1, 0, 8'h00, 8'h00, 0, 0, 0); idle(2);
    for (int i = 0; i < 4000; i++) begin
      bit r, l, sa, pa, t;
      logic [7:0] m, s;
      r  = ($urandom_range(0, 399) == 0);
      l  = ($urandom_range(0, 29) == 0);
      sa = ($urandom_range(0, 9) == 0);
      pa = ($urandom_range(0, 29) == 0);
      t  = ($urandom_range(0, 2) == 0);
      m  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 1));
      s  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 59));
      step(r, l, m, s, sa, pa, t);
    end
    idle(1);
    @(posedge clk); #2;
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Minutes/seconds countdown timer that consumes the 1 Hz tick produced by the clock divider stage. It holds a BCD MM:SS value, decrements it once per tick while running, and signals expiry. It drives the divider's stop input so the divider phase freezes whenever the timer is not running. This makes pause/resume exact to the divider's resolution.

## Interface
- p_auto_reload, 0: 1 = on expiry reload the last accepted value and keep running; 0 = stop in EXPIRED
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_tick  in  1  one-cycle pulse from the divider (o_out), 1 per second
- i_load  in  1  one-cycle request: load i_load_min/i_load_sec
- i_load_min  in  8  BCD minutes, 00..99
- i_load_sec  in  8  BCD seconds, 00..59
- i_start  in  1  one-cycle request: start or resume counting
- i_pause  in  1  one-cycle request: pause counting
- o_min  out  8  current BCD minutes
- o_sec  out  8  current BCD seconds
- o_busy  out  1  high in RUN
- o_stop  out  1  to divider i_stop; high when state is not RUN
- o_done  out  1  one-cycle pulse on reaching 00:00
- o_expired  out  1  high in EXPIRED
- o_err  out  1  one-cycle pulse on a rejected load

## Operation
- Internal registers: current value, reload value (last accepted load), state.
- States:
  - IDLE: value loaded, not counting.
  - RUN: counting.
  - PAUSE: halted mid-count.
  - EXPIRED: reached zero.
- Load validation: accept only if every nibble is ≤ 9, seconds tens is ≤ 5, and the value is not 00:00.
  - Accepted: current and reload values both take the new value.
  - Rejected: o_err pulses, the value is unchanged, the state is unchanged.
- Request priority, highest first: i_rst > i_load > i_pause > i_start > i_tick.
- An accepted i_load from any state moves the block to IDLE. A rejected i_load consumes the cycle; lower-priority requests in that cycle are ignored.
- IDLE: i_start → RUN if value ≠ 00:00; otherwise ignored.
- RUN:
  - i_pause → PAUSE; a tick in the same cycle is dropped.
  - i_tick alone decrements the value.
- PAUSE: i_start → RUN. Ticks are ignored.
- EXPIRED: only i_load leaves this state. i_start, i_pause and i_tick are ignored.
- Decrement rules:
  - Seconds units borrow from seconds tens.
  - Seconds 00 wraps to 59 with a borrow into minutes.
  - Minutes are decremented in BCD: units 0 → 9, borrowing from tens.
- Zero reached (value becomes 00:00 on a tick in RUN):
  - o_done pulses.
  - p_auto_reload = 0: state → EXPIRED, value holds 00:00.
  - p_auto_reload = 1: on the next tick the value reloads from the reload register and stays in RUN. The 00:00 display therefore lasts exactly one second; o_expired is never asserted.

## Timing
- Reset values: state IDLE, value 00:00, reload 00:00, o_busy 0, o_stop 1, o_done 0, o_expired 0, o_err 0.
- All outputs are registered or decoded directly from registers. There is no combinational path from inputs to outputs.
- A request sampled at edge N takes effect in the state and value registers at edge N.
  - o_busy/o_stop change in the cycle after the request.
  - o_done/o_err are high for exactly the one cycle after the triggering edge.
- o_stop deasserts the cycle after i_start is accepted, so the divider resumes counting from its held phase. The first tick after a resume therefore arrives after the remaining divider period, not a full second.
- o_done is asserted in the same cycle that o_min/o_sec first show 00:00.
- A tick arriving together with an accepted load is discarded.
- i_rst mid-RUN: the value clears and the block returns to IDLE; no o_done pulse.

## Test plan
- Reset, then load 01:05 → o_min=8'h01, o_sec=8'h05, o_stop=1. Start, then 6 ticks → 00:59, o_busy=1.
- Load 00:02, start, 2 ticks → o_done pulses once on the second tick; o_expired=1, o_stop=1; further ticks and i_start change nothing.
- Load 10:00, start, 1 tick → 09:59. Pause on the same cycle as a tick → value unchanged, o_stop=1. Start, 1 tick → 09:58.
- Load 00:60, then 0A:00, then 00:00 → o_err pulses 3 times; value and state are unchanged each time.
- With p_auto_reload=1: load 00:03, start, 3 ticks → 00:00 and o_done pulses; next tick → 00:03, o_busy stays 1, o_expired stays 0.
- In RUN, assert i_load (valid 00:30) and i_tick in the same cycle → value 00:30, state IDLE, no decrement. Assert i_rst mid-RUN → 00:00, IDLE, o_done=0.
